// File: rtl/player_pkg.sv
// Shared types and constants for the player-motion block: motion states,
// USB keycodes, the platform record layout and signed position helpers.
package player_pkg;

  typedef enum logic [1:0] {
    GROUNDED = 2'd0,
    RISING   = 2'd1,
    FALLING  = 2'd2
  } motion_state_t;

  localparam logic [7:0] KEY_JUMP  = 8'h1A;
  localparam logic [7:0] KEY_RIGHT = 8'h07;
  localparam logic [7:0] KEY_LEFT  = 8'h04;

  // One platform as carried on plat_bus; x_left sits in the top bits.
  typedef struct packed {
    logic [9:0] x_left;
    logic [9:0] x_right;
    logic [9:0] y_top;
  } platform_t;

  localparam int PLAT_W = 30;

  // Position arithmetic is done in 11-bit signed so that steps below zero
  // can be detected before clamping back to the 10-bit screen range.
  typedef logic signed [10:0] pos_s_t;

  function automatic pos_s_t to_s(input logic [9:0] v);
    return pos_s_t'({1'b0, v});
  endfunction

  function automatic logic [9:0] clamp10(input pos_s_t v);
    if (v[10]) begin
      return 10'd0;
    end
    return v[9:0];
  endfunction

endpackage

// File: rtl/platform_collide.sv
// Combinational platform search: reports whether the feet are resting on a
// platform or the ground, and the highest landing surface reachable this
// frame when moving down by vy.
module platform_collide
  import player_pkg::*;
#(
  parameter int NUM_PLAT = 4,
  parameter int GROUND_Y = 398
) (
  input  logic [NUM_PLAT*PLAT_W-1:0] plat_bus,
  input  logic [9:0]                 world_x,
  input  logic [9:0]                 feet,
  input  logic signed [5:0]          vy,
  output logic                       land_hit,
  output logic [9:0]                 land_y,
  output logic                       supported
);

  localparam logic [9:0] GROUND_U = 10'(GROUND_Y);

  pos_s_t    reach;
  platform_t plat;

  // Scan every platform; the ground is always a landing candidate once the
  // step would reach or pass it, and the smallest y_top wins.
  always_comb begin
    reach     = to_s(feet) + pos_s_t'(vy);
    land_hit  = (reach >= to_s(GROUND_U));
    land_y    = GROUND_U;
    supported = (feet == GROUND_U);
    plat      = '0;
    for (int i = 0; i < NUM_PLAT; i++) begin
      plat = platform_t'(plat_bus[i*PLAT_W +: PLAT_W]);
      if ((plat.x_left <= world_x) && (world_x <= plat.x_right)) begin
        if (plat.y_top == feet) begin
          supported = 1'b1;
        end
        if ((plat.y_top >= feet) && (to_s(plat.y_top) <= reach) &&
            (!land_hit || (plat.y_top < land_y))) begin
          land_hit = 1'b1;
          land_y   = plat.y_top;
        end
      end
    end
  end

endmodule

// File: rtl/player_motion.sv
// Per-frame player motion controller: key decode, walking with world
// scroll, edge-triggered jump, integer gravity and platform landing.
// Optional feature macro: PLAYER_DOUBLE_JUMP_EN (one extra airborne jump).
module player_motion
  import player_pkg::*;
#(
  parameter int X_START    = 80,
  parameter int GROUND_Y   = 398,
  parameter int SIZE_X     = 10,
  parameter int SIZE_Y     = 20,
  parameter int X_MIN      = 10,
  parameter int X_MAX      = 629,
  parameter int Y_MIN      = 20,
  parameter int X_STEP     = 1,
  parameter int JUMP_V     = 6,
  parameter int GRAV_DIV   = 2,
  parameter int MAX_FALL   = 6,
  parameter int SCROLL_X   = 320,
  parameter int SCROLL_MAX = 319,
  parameter int NUM_PLAT   = 4,
  parameter int STEP_DIV   = 8
) (
  input  logic                       frame_clk,
  input  logic                       Reset,
  input  logic [7:0]                 keycode,
  input  logic [7:0]                 keycode1,
  input  logic [NUM_PLAT*PLAT_W-1:0] plat_bus,
  output logic [9:0]                 pos_x,
  output logic [9:0]                 pos_y,
  output logic [9:0]                 scroll,
  output logic [9:0]                 size_x,
  output logic [9:0]                 size_y,
  output logic [1:0]                 state,
  output logic                       step_pulse
);

  localparam int GRAV_W = (GRAV_DIV > 1) ? $clog2(GRAV_DIV) : 1;
  localparam int STEP_W = ($clog2(STEP_DIV) > 3) ? $clog2(STEP_DIV) : 3;

  localparam logic [GRAV_W-1:0] GRAV_LAST = GRAV_W'(GRAV_DIV - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);

  localparam logic [9:0] X_START_U    = 10'(X_START);
  localparam logic [9:0] Y_REST_U     = 10'(GROUND_Y - SIZE_Y);
  localparam logic [9:0] X_MIN_U      = 10'(X_MIN);
  localparam logic [9:0] X_MAX_U      = 10'(X_MAX);
  localparam logic [9:0] Y_MIN_U      = 10'(Y_MIN);
  localparam logic [9:0] SCROLL_X_U   = 10'(SCROLL_X);
  localparam logic [9:0] SCROLL_MAX_U = 10'(SCROLL_MAX);

  localparam pos_s_t X_MIN_S      = pos_s_t'(X_MIN);
  localparam pos_s_t X_MAX_S      = pos_s_t'(X_MAX);
  localparam pos_s_t Y_MIN_S      = pos_s_t'(Y_MIN);
  localparam pos_s_t X_STEP_S     = pos_s_t'(X_STEP);
  localparam pos_s_t SIZE_Y_S     = pos_s_t'(SIZE_Y);
  localparam pos_s_t SCROLL_MAX_S = pos_s_t'(SCROLL_MAX);

  localparam logic signed [5:0] VY_JUMP = 6'(-JUMP_V);
  localparam logic signed [5:0] VY_MAX  = 6'(MAX_FALL);

  motion_state_t      cur_state, next_state;
  logic signed [5:0]  vy, vy_n, vy_inc;
  logic               jump_q;
  logic [GRAV_W-1:0]  grav_cnt, grav_n;
  logic [STEP_W-1:0]  step_cnt, step_n;
  logic               step_pulse_n;
  logic [9:0]         pos_x_n, pos_y_n, scroll_n;
  pos_s_t             x_s, y_s, scroll_s;

`ifdef PLAYER_DOUBLE_JUMP_EN
  logic air_jump_used, air_jump_used_n;
`endif

  logic key_jump, key_right, key_left;
  logic move_left, move_right, jump_edge, grav_tick;
  logic [9:0] world_x, feet;
  logic land_hit, supported;
  logic [9:0] land_y;

  assign key_jump   = (keycode == KEY_JUMP)  || (keycode1 == KEY_JUMP);
  assign key_right  = (keycode == KEY_RIGHT) || (keycode1 == KEY_RIGHT);
  assign key_left   = (keycode == KEY_LEFT)  || (keycode1 == KEY_LEFT);
  assign move_left  = key_left & ~key_right;
  assign move_right = key_right & ~key_left;
  assign jump_edge  = key_jump & ~jump_q;
  assign world_x    = pos_x + scroll;
  assign feet       = pos_y + 10'(SIZE_Y);
  assign grav_tick  = (grav_cnt == GRAV_LAST);

  assign state  = cur_state;
  assign size_x = 10'(SIZE_X);
  assign size_y = 10'(SIZE_Y);

  platform_collide #(
    .NUM_PLAT (NUM_PLAT),
    .GROUND_Y (GROUND_Y)
  ) u_collide (
    .plat_bus  (plat_bus),
    .world_x   (world_x),
    .feet      (feet),
    .vy        (vy),
    .land_hit  (land_hit),
    .land_y    (land_y),
    .supported (supported)
  );

  // Frame register: all motion state advances once per frame.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      pos_x      <= X_START_U;
      pos_y      <= Y_REST_U;
      scroll     <= '0;
      cur_state  <= GROUNDED;
      vy         <= '0;
      jump_q     <= 1'b0;
      grav_cnt   <= '0;
      step_cnt   <= '0;
      step_pulse <= 1'b0;
`ifdef PLAYER_DOUBLE_JUMP_EN
      air_jump_used <= 1'b0;
`endif
    end else begin
      pos_x      <= pos_x_n;
      pos_y      <= pos_y_n;
      scroll     <= scroll_n;
      cur_state  <= next_state;
      vy         <= vy_n;
      jump_q     <= key_jump;
      grav_cnt   <= grav_n;
      step_cnt   <= step_n;
      step_pulse <= step_pulse_n;
`ifdef PLAYER_DOUBLE_JUMP_EN
      air_jump_used <= air_jump_used_n;
`endif
    end
  end

  // Horizontal walk; right-walk past the scroll line moves the world instead.
  always_comb begin
    pos_x_n  = pos_x;
    scroll_n = scroll;
    x_s      = to_s(pos_x);
    scroll_s = to_s(scroll) + X_STEP_S;
    if (move_left) begin
      x_s     = to_s(pos_x) - X_STEP_S;
      pos_x_n = (x_s < X_MIN_S) ? X_MIN_U : clamp10(x_s);
    end else if (move_right) begin
      if ((pos_x >= SCROLL_X_U) && (scroll < SCROLL_MAX_U)) begin
        scroll_n = (scroll_s > SCROLL_MAX_S) ? SCROLL_MAX_U : clamp10(scroll_s);
      end else begin
        x_s     = to_s(pos_x) + X_STEP_S;
        pos_x_n = (x_s > X_MAX_S) ? X_MAX_U : clamp10(x_s);
      end
    end
  end

  // Vertical next-state: jump, rise against the ceiling, fall and land.
  always_comb begin
    next_state = cur_state;
    vy_n       = vy;
    pos_y_n    = pos_y;
    y_s        = to_s(pos_y) + pos_s_t'(vy);
    vy_inc     = vy + (grav_tick ? 6'sd1 : 6'sd0);
`ifdef PLAYER_DOUBLE_JUMP_EN
    air_jump_used_n = air_jump_used;
`endif
    case (cur_state)
      GROUNDED: begin
        if (jump_edge) begin
          vy_n       = VY_JUMP;
          next_state = RISING;
        end else if (!supported) begin
          vy_n       = '0;
          next_state = FALLING;
        end
      end
      RISING: begin
        if (y_s < Y_MIN_S) begin
          pos_y_n    = Y_MIN_U;
          vy_n       = '0;
          next_state = FALLING;
        end else begin
          pos_y_n = clamp10(y_s);
          vy_n    = vy_inc;
          if (!vy_inc[5]) begin
            next_state = FALLING;
          end
        end
      end
      FALLING: begin
        if (land_hit) begin
          pos_y_n    = clamp10(to_s(land_y) - SIZE_Y_S);
          vy_n       = '0;
          next_state = GROUNDED;
`ifdef PLAYER_DOUBLE_JUMP_EN
          air_jump_used_n = 1'b0;
`endif
        end else begin
          pos_y_n = clamp10(y_s);
          vy_n    = (vy_inc > VY_MAX) ? VY_MAX : vy_inc;
        end
      end
      default: begin
        next_state = GROUNDED;
      end
    endcase
`ifdef PLAYER_DOUBLE_JUMP_EN
    if ((cur_state != GROUNDED) && !((cur_state == FALLING) && land_hit) &&
        jump_edge && !air_jump_used) begin
      vy_n            = VY_JUMP;
      next_state      = RISING;
      air_jump_used_n = 1'b1;
    end
`endif
  end

  // Gravity divider counts airborne frames and restarts on any state change.
  always_comb begin
    grav_n = '0;
    if ((next_state == cur_state) && (cur_state != GROUNDED) && !grav_tick) begin
      grav_n = grav_cnt + 1'b1;
    end
  end

  // Footstep counter: pulses every STEP_DIV frames of walking on the ground.
  always_comb begin
    step_n       = '0;
    step_pulse_n = 1'b0;
    if ((cur_state == GROUNDED) && (move_left || move_right)) begin
      if (step_cnt == STEP_LAST) begin
        step_pulse_n = 1'b1;
      end else begin
        step_n = step_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_player_motion.sv
// Self-checking bench for player_motion: a table of key phases with hand
// checkpoints, a per-frame reference model feeding a scoreboard queue, and
// hand-written reset-mid-jump and airborne-press sequences.
// Honours PLAYER_DOUBLE_JUMP_EN in its reference model.
module tb_player_motion;

  logic         frame_clk = 1'b0;
  logic         Reset;
  logic [7:0]   keycode, keycode1;
  logic [119:0] plat_bus;
  logic [9:0]   pos_x, pos_y, scroll, size_x, size_y;
  logic [1:0]   state;
  logic         step_pulse;

  int n_tests = 0;
  int n_fail  = 0;
  int pulse_seen = 0;

  int pxl[4] = '{200, 1000, 1000, 1000};
  int pxr[4] = '{260, 1020, 1020, 1020};
  int pyt[4] = '{360, 100, 150, 200};

  int m_x, m_y, m_sc, m_st, m_vy, m_gc, m_stc, m_pulse, m_jq, m_air;

  typedef struct {
    string tag;
    int    x;
    int    y;
    int    sc;
    int    st;
    int    pulse;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    string      name;
    logic [7:0] k0;
    logic [7:0] k1;
    int         frames;
    int         ex;
    int         ey;
    int         esc;
    int         est;
    int         epulses;
  } vec_t;

  vec_t vecs[15];

  player_motion dut (
    .frame_clk  (frame_clk),
    .Reset      (Reset),
    .keycode    (keycode),
    .keycode1   (keycode1),
    .plat_bus   (plat_bus),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .scroll     (scroll),
    .size_x     (size_x),
    .size_y     (size_y),
    .state      (state),
    .step_pulse (step_pulse)
  );

  always #5 frame_clk = ~frame_clk;

  function automatic vec_t mkVec(string n, logic [7:0] a, logic [7:0] b, int f,
                                 int x, int y, int sc, int st, int p);
    vec_t v;
    v.name = n; v.k0 = a; v.k1 = b; v.frames = f;
    v.ex = x; v.ey = y; v.esc = sc; v.est = st; v.epulses = p;
    return v;
  endfunction

  task automatic checkValue(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic modelReset();
    m_x = 80; m_y = 378; m_sc = 0; m_st = 0; m_vy = 0;
    m_gc = 0; m_stc = 0; m_pulse = 0; m_jq = 0; m_air = 0;
  endtask

  task automatic modelStep(input logic [7:0] k0, input logic [7:0] k1);
    bit kj, kr, kl, ml, mr, edge_j, hit, sup;
    int feet, wx, reach, tick, nx, nsc, ny, nvy, nst, ngc, best, nair;
    kj = (k0 == 8'h1A) || (k1 == 8'h1A);
    kr = (k0 == 8'h07) || (k1 == 8'h07);
    kl = (k0 == 8'h04) || (k1 == 8'h04);
    ml = kl && !kr;
    mr = kr && !kl;
    edge_j = kj && (m_jq == 0);
    feet  = m_y + 20;
    wx    = m_x + m_sc;
    reach = feet + m_vy;
    tick  = (m_gc == 1) ? 1 : 0;
    nx = m_x; nsc = m_sc;
    if (ml) nx = (m_x - 1 < 10) ? 10 : m_x - 1;
    else if (mr) begin
      if (m_x >= 320 && m_sc < 319) nsc = m_sc + 1;
      else nx = (m_x + 1 > 629) ? 629 : m_x + 1;
    end
    sup = (feet == 398);
    hit = (reach >= 398);
    best = 398;
    for (int i = 0; i < 4; i++) begin
      if (wx >= pxl[i] && wx <= pxr[i]) begin
        if (pyt[i] == feet) sup = 1;
        if (pyt[i] >= feet && pyt[i] <= reach && (!hit || pyt[i] < best)) begin
          hit = 1;
          best = pyt[i];
        end
      end
    end
    ny = m_y; nvy = m_vy; nst = m_st; nair = m_air;
    if (m_st == 0) begin
      if (edge_j) begin nvy = -6; nst = 1; end
      else if (!sup) begin nvy = 0; nst = 2; end
    end else if (m_st == 1) begin
      if (m_y + m_vy < 20) begin ny = 20; nvy = 0; nst = 2; end
      else begin
        ny = m_y + m_vy;
        nvy = m_vy + tick;
        if (nvy >= 0) nst = 2;
      end
    end else begin
      if (hit) begin ny = best - 20; nvy = 0; nst = 0; nair = 0; end
      else begin
        ny = m_y + m_vy;
        nvy = m_vy + tick;
        if (nvy > 6) nvy = 6;
      end
    end
`ifdef PLAYER_DOUBLE_JUMP_EN
    if (m_st != 0 && !(m_st == 2 && hit) && edge_j && m_air == 0) begin
      nvy = -6; nst = 1; nair = 1;
    end
`endif
    if (nst != m_st || m_st == 0) ngc = 0;
    else ngc = (tick == 1) ? 0 : m_gc + 1;
    if (m_st == 0 && (ml || mr)) begin
      m_pulse = (m_stc == 7) ? 1 : 0;
      m_stc = (m_stc == 7) ? 0 : m_stc + 1;
    end else begin
      m_pulse = 0;
      m_stc = 0;
    end
    m_x = nx; m_sc = nsc; m_y = ny; m_vy = nvy; m_st = nst; m_gc = ngc;
    m_air = nair; m_jq = kj ? 1 : 0;
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("[TB] FAIL %s: scoreboard empty at output", tag);
      return;
    end
    e = sb.pop_front();
    if (step_pulse) pulse_seen++;
    if (pos_x !== 10'(e.x) || pos_y !== 10'(e.y) || scroll !== 10'(e.sc) ||
        state !== 2'(e.st) || step_pulse !== 1'(e.pulse)) begin
      n_fail++;
      $display("[TB] FAIL %s: got x=%0d y=%0d scroll=%0d state=%0d pulse=%0d, expected x=%0d y=%0d scroll=%0d state=%0d pulse=%0d",
               e.tag, pos_x, pos_y, scroll, state, step_pulse,
               e.x, e.y, e.sc, e.st, e.pulse);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] k0, input logic [7:0] k1, input string tag);
    exp_t e;
    @(negedge frame_clk);
    keycode  = k0;
    keycode1 = k1;
    modelStep(k0, k1);
    e.tag = tag; e.x = m_x; e.y = m_y; e.sc = m_sc; e.st = m_st; e.pulse = m_pulse;
    sb.push_back(e);
    @(posedge frame_clk);
    #1;
    checkOutput(tag);
  endtask

  task automatic checkResetValues(input string tag);
    checkValue({tag, "_x"}, int'(pos_x), 80);
    checkValue({tag, "_y"}, int'(pos_y), 378);
    checkValue({tag, "_scroll"}, int'(scroll), 0);
    checkValue({tag, "_state"}, int'(state), 0);
    checkValue({tag, "_pulse"}, int'(step_pulse), 0);
  endtask

  initial begin
    vecs[0]  = mkVec("walk_right",    8'h07, 8'h00, 260, 320, 378, 20, 0, 32);
    vecs[1]  = mkVec("idle",          8'h00, 8'h00,   2, 320, 378, 20, 0,  0);
    vecs[2]  = mkVec("jump_press",    8'h1A, 8'h00,   1, 320, 378, 20, 1, -1);
    vecs[3]  = mkVec("jump_rise",     8'h1A, 8'h00,  12, 320, 336, 20, 2, -1);
    vecs[4]  = mkVec("jump_hold",     8'h1A, 8'h00,  87, 320, 378, 20, 0, -1);
    vecs[5]  = mkVec("release",       8'h00, 8'h00,   1, 320, 378, 20, 0, -1);
    vecs[6]  = mkVec("rejump",        8'h00, 8'h1A,   1, 320, 378, 20, 1, -1);
    vecs[7]  = mkVec("land_again",    8'h00, 8'h00,  40, 320, 378, 20, 0, -1);
    vecs[8]  = mkVec("walk_left",     8'h04, 8'h00, 120, 200, 378, 20, 0, 15);
    vecs[9]  = mkVec("jump_right",    8'h1A, 8'h07,   1, 201, 378, 20, 1, -1);
    vecs[10] = mkVec("onto_platform", 8'h07, 8'h00,  17, 218, 340, 20, 0, -1);
    vecs[11] = mkVec("walk_off",      8'h07, 8'h00,  24, 242, 340, 20, 2,  3);
    vecs[12] = mkVec("fall_ground",   8'h00, 8'h00,  40, 242, 378, 20, 0, -1);
    vecs[13] = mkVec("both_lr",       8'h04, 8'h07,  10, 242, 378, 20, 0,  0);
    vecs[14] = mkVec("left_clamp",    8'h04, 8'h00, 250,  10, 378, 20, 0, 31);

    for (int i = 0; i < 4; i++) begin
      plat_bus[i*30 +: 30] = {10'(pxl[i]), 10'(pxr[i]), 10'(pyt[i])};
    end
    keycode  = 8'h00;
    keycode1 = 8'h00;
    Reset    = 1'b1;
    modelReset();
    #2;
    checkResetValues("reset");
    checkValue("size_x", int'(size_x), 10);
    checkValue("size_y", int'(size_y), 20);
    @(negedge frame_clk);
    Reset = 1'b0;

    for (int v = 0; v < 15; v++) begin
      pulse_seen = 0;
      for (int f = 0; f < vecs[v].frames; f++) begin
        applyStimulus(vecs[v].k0, vecs[v].k1, vecs[v].name);
      end
      checkValue({vecs[v].name, "_x"}, int'(pos_x), vecs[v].ex);
      checkValue({vecs[v].name, "_y"}, int'(pos_y), vecs[v].ey);
      checkValue({vecs[v].name, "_scroll"}, int'(scroll), vecs[v].esc);
      checkValue({vecs[v].name, "_state"}, int'(state), vecs[v].est);
      if (vecs[v].epulses >= 0) begin
        checkValue({vecs[v].name, "_pulses"}, pulse_seen, vecs[v].epulses);
      end
    end

    // Reset asserted mid-rise takes effect between frame edges.
    applyStimulus(8'h1A, 8'h00, "pre_reset_jump");
    for (int f = 0; f < 4; f++) applyStimulus(8'h00, 8'h00, "pre_reset_rise");
    checkValue("pre_reset_state", int'(state), 1);
    #2;
    Reset = 1'b1;
    #1;
    checkResetValues("mid_rise_reset");
    @(negedge frame_clk);
    Reset = 1'b0;
    modelReset();
    applyStimulus(8'h1A, 8'h00, "fresh_jump");
    checkValue("fresh_jump_state", int'(state), 1);
    checkValue("fresh_jump_y", int'(pos_y), 378);
    for (int f = 0; f < 40; f++) applyStimulus(8'h00, 8'h00, "fresh_land");
    checkValue("fresh_land_y", int'(pos_y), 378);

    // Airborne presses: second press (air jump when enabled), then a third.
    applyStimulus(8'h1A, 8'h00, "air_first");
    for (int f = 0; f < 2; f++) applyStimulus(8'h00, 8'h00, "air_gap1");
    applyStimulus(8'h1A, 8'h00, "air_second");
    checkValue("air_second_y", int'(pos_y), 361);
    checkValue("air_second_state", int'(state), 1);
    for (int f = 0; f < 2; f++) applyStimulus(8'h00, 8'h00, "air_gap2");
    applyStimulus(8'h00, 8'h1A, "air_third");
    for (int f = 0; f < 60; f++) applyStimulus(8'h00, 8'h00, "air_land");
    checkValue("air_land_y", int'(pos_y), 378);
    checkValue("air_land_state", int'(state), 0);
    checkValue("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
